// File: rtl/fractional_n_pkg.sv
// fractional_n_pkg: shared constants and types for the fractional-N divider.
package fractional_n_pkg;
    localparam int P_W = 5;
    localparam int S_W = 3;
    localparam int INT_W = P_W + S_W;
    localparam int FRAC_W = 24;
    localparam int N_MIN = (2**S_W) * (2**S_W - 1);
    localparam int N_MAX = 2**INT_W - 1;
    typedef logic signed [3:0] mash_t;
endpackage

// File: rtl/mash111_modulator.sv
// mash111_modulator: three cascaded accumulators with noise-shaped carry recombination.
module mash111_modulator
    import fractional_n_pkg::*;
#(
    parameter int FRAC_WIDTH = FRAC_W
) (
    input  logic                  Fin,
    input  logic                  rst_n,
    input  logic                  step_en,
    input  logic [FRAC_WIDTH-1:0] Fraction,
    output mash_t                 mash_out
);
    logic [FRAC_WIDTH-1:0] acc1, acc2, acc3;
    logic [FRAC_WIDTH:0] s1, s2, s3;
    logic c1, c2, c3, c2_d, c3_d, c3_dd;

    assign s1 = {1'b0, acc1} + {1'b0, Fraction};
    assign s2 = {1'b0, acc2} + {1'b0, s1[FRAC_WIDTH-1:0]};
    assign s3 = {1'b0, acc3} + {1'b0, s2[FRAC_WIDTH-1:0]};

    always_ff @(posedge Fin or negedge rst_n) begin
        if (!rst_n) begin
            {acc1, acc2, acc3} <= '0;
            {c1, c2, c3, c2_d, c3_d, c3_dd} <= '0;
        end else if (step_en) begin
            acc1 <= s1[FRAC_WIDTH-1:0];
            acc2 <= s2[FRAC_WIDTH-1:0];
            acc3 <= s3[FRAC_WIDTH-1:0];
            c1 <= s1[FRAC_WIDTH];
            c2 <= s2[FRAC_WIDTH];
            c3 <= s3[FRAC_WIDTH];
            c2_d <= c2;
            c3_d <= c3;
            c3_dd <= c3_d;
        end
    end

    // 4-bit wrap in intermediates is harmless: the final sum always lies in -3..+4
    assign mash_out = $signed({3'b0, c1}) + $signed({3'b0, c2}) - $signed({3'b0, c2_d})
                    + $signed({3'b0, c3}) - $signed({2'b0, c3_d, 1'b0}) + $signed({3'b0, c3_dd});
endmodule

// File: rtl/fractional_n_divider.sv
// fractional_n_divider: pulse-swallow divider whose ratio is dithered by a MASH 1-1-1 modulator.
// Define FRACN_DITHER_EN to XOR a 16-bit LFSR bit into Fraction bit 0 each period.
module fractional_n_divider
    import fractional_n_pkg::*;
#(
    parameter int P_WIDTH = P_W,
    parameter int S_WIDTH = S_W,
    parameter int INT_WIDTH = INT_W,
    parameter int FRAC_WIDTH = FRAC_W
) (
    input  logic                  Fin,
    input  logic                  rst_n,
    input  logic [INT_WIDTH-1:0]  Integer,
    input  logic [FRAC_WIDTH-1:0] Fraction,
    output logic                  Fout
);
    localparam logic signed [INT_WIDTH+1:0] N_LO = (INT_WIDTH+2)'((2**S_WIDTH) * (2**S_WIDTH - 1));
    localparam logic signed [INT_WIDTH+1:0] N_HI = (INT_WIDTH+2)'(2**INT_WIDTH - 1);
    localparam logic [S_WIDTH:0] PRE_LONG = (S_WIDTH+1)'(2**S_WIDTH);
    localparam logic [S_WIDTH:0] PRE_SHORT = (S_WIDTH+1)'(2**S_WIDTH - 1);

    logic run, ld;
    logic [S_WIDTH:0] pre, pre_n;
    logic [P_WIDTH-1:0] p_left, p_n;
    logic [S_WIDTH-1:0] s_left, s_n;
    logic [FRAC_WIDTH-1:0] frac;
    logic signed [INT_WIDTH+1:0] n_raw;
    logic [INT_WIDTH-1:0] n_ld;
    mash_t mash_out;

    // the first edge after reset loads a period just like a period end does
    assign ld = Fout | ~run;

`ifdef FRACN_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge Fin or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else if (ld) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    assign frac = Fraction ^ {{(FRAC_WIDTH-1){1'b0}}, lfsr[0]};
`else
    assign frac = Fraction;
`endif

    mash111_modulator #(.FRAC_WIDTH(FRAC_WIDTH)) u_mash (
        .Fin(Fin),
        .rst_n(rst_n),
        .step_en(ld),
        .Fraction(frac),
        .mash_out(mash_out)
    );

    assign n_raw = $signed({2'b0, Integer}) + (INT_WIDTH+2)'(mash_out);
    assign n_ld = n_raw < N_LO ? N_LO[INT_WIDTH-1:0] : n_raw > N_HI ? N_HI[INT_WIDTH-1:0] : n_raw[INT_WIDTH-1:0];

    // pre counts down one prescaler cycle; the first s_left cycles of a period are one longer
    always_comb begin
        p_n = ld ? n_ld[INT_WIDTH-1:S_WIDTH] - 1'b1 : pre == '0 ? p_left - 1'b1 : p_left;
        s_n = ld ? n_ld[S_WIDTH-1:0] : (pre == '0 && s_left != '0) ? s_left - 1'b1 : s_left;
        pre_n = (ld || pre == '0) ? (s_n != '0 ? PRE_LONG : PRE_SHORT) : pre - 1'b1;
    end

    always_ff @(posedge Fin or negedge rst_n) begin
        if (!rst_n) begin
            {run, pre, p_left, s_left, Fout} <= '0;
        end else begin
            run <= 1'b1;
            pre <= pre_n;
            p_left <= p_n;
            s_left <= s_n;
            Fout <= pre_n == '0 && p_n == '0;
        end
    end
endmodule

// File: tb/tb_fractional_n_divider.sv
// tb_fractional_n_divider: directed checks of period length, ratio averaging, reset and clamping.
module tb_fractional_n_divider;
    logic Fin = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] Integer = 8'd132;
    logic [23:0] Fraction = 24'd0;
    logic Fout;
    int checks = 0;
    int failures = 0;
    int n, first, lo, hi, total;

    fractional_n_divider dut (
        .Fin(Fin),
        .rst_n(rst_n),
        .Integer(Integer),
        .Fraction(Fraction),
        .Fout(Fout)
    );

    always #5 Fin = ~Fin;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // counts Fin edges until Fout is seen high; returns at the falling edge of that cycle
    task automatic wait_pulse(output int cnt);
        cnt = 0;
        do begin
            @(posedge Fin);
            cnt++;
            @(negedge Fin);
        end while (!Fout && cnt < 1000);
        if (!Fout) chk("pulse_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge Fin);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_periods(input int k, output int f, output int mn, output int mx, output int sum);
        int p;
        mn = 1000;
        mx = 0;
        sum = 0;
        f = 0;
        for (int i = 0; i < k; i++) begin
            wait_pulse(p);
            if (i == 0) f = p;
            if (p < mn) mn = p;
            if (p > mx) mx = p;
            sum += p;
        end
    endtask

    initial begin
        repeat (2) @(posedge Fin);
        @(negedge Fin);
        chk("reset_fout", int'(Fout), 0);
        @(posedge Fin);
        #1 rst_n = 1'b1;
        wait_pulse(n);
        chk("first_132", n, 132);
        for (int i = 0; i < 4; i++) begin
            wait_pulse(n);
            chk("period_132", n, 132);
        end
        rst_n = 1'b0;
        #1 chk("async_drop", int'(Fout), 0);
        repeat (2) @(posedge Fin);
        #1 rst_n = 1'b1;
        wait_pulse(n);
        chk("after_reset_first", n, 132);
        wait_pulse(n);
        chk("after_reset_next", n, 132);
        repeat (40) @(posedge Fin);
        #1 Integer = 8'd64;
        wait_pulse(n);
        chk("old_ratio_finish", n, 92);
        wait_pulse(n);
        chk("new_ratio_64", n, 64);
        wait_pulse(n);
        chk("new_ratio_64b", n, 64);

        Integer = 8'd132;
        Fraction = 24'd8388607;
        do_reset();
        run_periods(256, first, lo, hi, total);
        chk("half_first", first, 132);
        chk("half_min_ge_129", int'(lo >= 129), 1);
        chk("half_max_le_136", int'(hi <= 136), 1);
        chk("half_total", int'(total - 33919 >= -1 && total - 33919 <= 2), 1);

        Integer = 8'd100;
        Fraction = 24'd4194304;
        do_reset();
        run_periods(256, first, lo, hi, total);
        chk("quarter_first", first, 100);
        chk("quarter_min_ge_97", int'(lo >= 97), 1);
        chk("quarter_max_le_104", int'(hi <= 104), 1);
        chk("quarter_total", int'(total - 25663 >= -1 && total - 25663 <= 2), 1);

        Integer = 8'd58;
        Fraction = 24'd8388607;
        do_reset();
        run_periods(100, first, lo, hi, total);
        chk("clamp_min_ge_56", int'(lo >= 56), 1);
        chk("clamp_max_le_62", int'(hi <= 62), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
